// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared state type and sizing helpers for systolic_array_ws
// Build option: SA_OUT_DESKEW_EN adds per-column output alignment and lengthens DRAIN to match.
package sa_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READY,
    ST_COMPUTE,
    ST_DRAIN
  } state_e;

`ifdef SA_OUT_DESKEW_EN
  localparam int DESKEW_ON = 1;
`else
  localparam int DESKEW_ON = 0;
`endif

  // Row r of the ifmap is delayed r cycles so it meets the psum wavefront.
  function automatic int skew_depth(input int row);
    return row;
  endfunction

  // Extra stages on column col so every column lands on the last column's cycle.
  function automatic int deskew_depth(input int cols, input int col);
    return (cols - 1 - col) * DESKEW_ON;
  endfunction

  // Cycles spent in DRAIN after the last accepted vector.
  function automatic int drain_len(input int rows, input int cols);
    return rows + cols - 1 + deskew_depth(cols, 0);
  endfunction

  // Cycles from vector acceptance to the result on column col.
  function automatic int out_latency(input int rows, input int cols, input int col);
    return rows + col + deskew_depth(cols, col);
  endfunction

  // LSB position of element idx in a flattened bus of width-bit elements.
  function automatic int lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - weight-stationary signed MAC processing element
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   w_shift_i         load w_i into the weight register (weights shift down the column)
//   w_i / w_o         weight from the PE above / current weight to the PE below
//   x_i, x_valid_i    ifmap element and its valid bit from the left
//   x_o, x_valid_o    registered ifmap element and valid to the right
//   psum_i / psum_o   partial sum from above / registered psum_i + x_i*w to below
module sa_pe
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_shift_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  output logic [DATA_WIDTH-1:0] w_o,
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic                  x_valid_i,
  output logic [DATA_WIDTH-1:0] x_o,
  output logic                  x_valid_o,
  input  logic [PSUM_WIDTH-1:0] psum_i,
  output logic [PSUM_WIDTH-1:0] psum_o
);

  logic [DATA_WIDTH-1:0]          w_q, w_d;
  logic [DATA_WIDTH-1:0]          x_q, x_d;
  logic                           x_valid_q, x_valid_d;
  logic [PSUM_WIDTH-1:0]          psum_q, psum_d;
  logic signed [2*DATA_WIDTH-1:0] prod;

  always_comb begin
    w_d       = w_shift_i ? w_i : w_q;
    x_d       = x_i;
    x_valid_d = x_valid_i;
    prod      = $signed(x_i) * $signed(w_q);
    // Invalid slots arrive with x_i = 0, so they add nothing to the column.
    psum_d    = psum_i + {{(PSUM_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q       <= '0;
      x_q       <= '0;
      x_valid_q <= 1'b0;
      psum_q    <= '0;
    end else begin
      w_q       <= w_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      psum_q    <= psum_d;
    end
  end

  assign w_o       = w_q;
  assign x_o       = x_q;
  assign x_valid_o = x_valid_q;
  assign psum_o    = psum_q;

endmodule

// File: rtl/systolic_array_ws.sv
// rtl/systolic_array_ws.sv - ROWS x COLS weight-stationary systolic array with preload FSM
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   w_load_i                        request weight reload (IDLE/READY only)
//   w_valid_i, w_data_i, w_ready_o  weight row beats; first beat ends in row ROWS-1
//   ifmap_valid_i, ifmap_data_i,
//   ifmap_last_i, ifmap_ready_o     ifmap vectors; last flags the end of a batch
//   psum_valid_o, psum_data_o       per-column results, y[c] = sum_r x[r]*W[r][c]
//   busy_o                          LOAD, COMPUTE or DRAIN
//   done_o                          one-cycle pulse at the end of DRAIN
// Build option: SA_OUT_DESKEW_EN aligns all columns to the last column's latency.
module systolic_array_ws
  import sa_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_load_i,
  input  logic                       w_valid_i,
  input  logic [COLS*DATA_WIDTH-1:0] w_data_i,
  output logic                       w_ready_o,
  input  logic                       ifmap_valid_i,
  input  logic [ROWS*DATA_WIDTH-1:0] ifmap_data_i,
  input  logic                       ifmap_last_i,
  output logic                       ifmap_ready_o,
  output logic [COLS-1:0]            psum_valid_o,
  output logic [COLS*PSUM_WIDTH-1:0] psum_data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int DRAIN_LEN = drain_len(ROWS, COLS);
  localparam int CNT_W     = $clog2(DRAIN_LEN + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             w_shift;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    w_ready_o     = 1'b0;
    ifmap_ready_o = 1'b0;
    done_o        = 1'b0;
    busy_o        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_load_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        w_ready_o = 1'b1;
        busy_o    = 1'b1;
        if (w_valid_i) begin
          if (cnt_q == CNT_W'(ROWS - 1)) begin
            state_d = ST_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_READY: begin
        ifmap_ready_o = 1'b1;
        // A vector wins over a simultaneous reload request.
        if (ifmap_valid_i) begin
          state_d = ifmap_last_i ? ST_DRAIN : ST_COMPUTE;
          cnt_d   = '0;
        end else if (w_load_i) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_COMPUTE: begin
        ifmap_ready_o = 1'b1;
        busy_o        = 1'b1;
        if (ifmap_valid_i && ifmap_last_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          done_o  = 1'b1;
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign accept  = ifmap_valid_i & ifmap_ready_o;
  assign w_shift = w_valid_i & w_ready_o;

  // Grid interconnect: x/valid run right (index COLS is the unused right edge),
  // weights and psums run down (index ROWS is the bottom edge).
  logic [COLS:0][DATA_WIDTH-1:0]   x_h [ROWS];
  logic [COLS:0]                   v_h [ROWS];
  logic [COLS-1:0][DATA_WIDTH-1:0] w_v [ROWS+1];
  logic [COLS-1:0][PSUM_WIDTH-1:0] p_v [ROWS+1];

  assign w_v[0] = w_data_i;
  assign p_v[0] = '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    localparam int D = skew_depth(r);
    logic [DATA_WIDTH:0] row_in;
    assign row_in = accept ? {1'b1, ifmap_data_i[lsb(r, DATA_WIDTH) +: DATA_WIDTH]} : '0;
    if (D == 0) begin : g_pass
      assign {v_h[r][0], x_h[r][0]} = row_in;
    end else begin : g_pipe
      logic [DATA_WIDTH:0] sk_q [D];
      logic [DATA_WIDTH:0] sk_d [D];
      always_comb begin
        sk_d[0] = row_in;
        for (int i = 1; i < D; i++) sk_d[i] = sk_q[i-1];
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) sk_q[i] <= rst ? '0 : sk_d[i];
      end
      assign {v_h[r][0], x_h[r][0]} = sk_q[D-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .PSUM_WIDTH (PSUM_WIDTH)
      ) u_pe (
        .clk       (clk),
        .rst       (rst),
        .w_shift_i (w_shift),
        .w_i       (w_v[r][c]),
        .w_o       (w_v[r+1][c]),
        .x_i       (x_h[r][c]),
        .x_valid_i (v_h[r][c]),
        .x_o       (x_h[r][c+1]),
        .x_valid_o (v_h[r][c+1]),
        .psum_i    (p_v[r][c]),
        .psum_o    (p_v[r+1][c])
      );
    end
  end

  // The bottom PE's registered valid is captured on the same edge as its psum.
  for (genvar c = 0; c < COLS; c++) begin : g_out
    localparam int D = deskew_depth(COLS, c);
    logic [PSUM_WIDTH:0] col_out;
    assign col_out = {v_h[ROWS-1][c+1], p_v[ROWS][c]};
    if (D == 0) begin : g_pass
      assign {psum_valid_o[c], psum_data_o[lsb(c, PSUM_WIDTH) +: PSUM_WIDTH]} = col_out;
    end else begin : g_pipe
      logic [PSUM_WIDTH:0] dk_q [D];
      logic [PSUM_WIDTH:0] dk_d [D];
      always_comb begin
        dk_d[0] = col_out;
        for (int i = 1; i < D; i++) dk_d[i] = dk_q[i-1];
      end
      always_ff @(posedge clk) begin
        for (int i = 0; i < D; i++) dk_q[i] <= rst ? '0 : dk_d[i];
      end
      assign {psum_valid_o[c], psum_data_o[lsb(c, PSUM_WIDTH) +: PSUM_WIDTH]} = dk_q[D-1];
    end
  end

  logic [ROWS-1:0] unused_edge;
  for (genvar r = 0; r < ROWS; r++) begin : g_edge
    assign unused_edge[r] = ^{x_h[r][COLS], v_h[r][COLS], w_v[r+1]};
  end

endmodule

// File: tb/tb_systolic_array_ws.sv
// tb/tb_systolic_array_ws.sv - directed self-checking bench for systolic_array_ws
`timescale 1ns/1ps
module tb_systolic_array_ws;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int PW   = 32;
`ifdef SA_OUT_DESKEW_EN
  localparam bit DESKEW = 1'b1;
`else
  localparam bit DESKEW = 1'b0;
`endif
  localparam int DONE_LAT = DESKEW ? 10 : 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               w_load_i = 1'b0;
  logic               w_valid_i = 1'b0;
  logic [COLS*DW-1:0] w_data_i = '0;
  logic               w_ready_o;
  logic               ifmap_valid_i = 1'b0;
  logic [ROWS*DW-1:0] ifmap_data_i = '0;
  logic               ifmap_last_i = 1'b0;
  logic               ifmap_ready_o;
  logic [COLS-1:0]    psum_valid_o;
  logic [COLS*PW-1:0] psum_data_o;
  logic               busy_o;
  logic               done_o;

  systolic_array_ws #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .DATA_WIDTH (DW),
    .PSUM_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .w_load_i      (w_load_i),
    .w_valid_i     (w_valid_i),
    .w_data_i      (w_data_i),
    .w_ready_o     (w_ready_o),
    .ifmap_valid_i (ifmap_valid_i),
    .ifmap_data_i  (ifmap_data_i),
    .ifmap_last_i  (ifmap_last_i),
    .ifmap_ready_o (ifmap_ready_o),
    .psum_valid_o  (psum_valid_o),
    .psum_data_o   (psum_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;
  int res_v [COLS][$];
  int res_t [COLS][$];
  int done_n = 0;
  int done_t = 0;

  always @(negedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      if (psum_valid_o[c]) begin
        res_v[c].push_back($signed(psum_data_o[c*PW +: PW]));
        res_t[c].push_back(cyc);
      end
    end
    if (done_o) begin
      done_n = done_n + 1;
      done_t = cyc;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    tests = tests + 1;
    if (got !== exp) begin
      failed = failed + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_t(input int t, input int c);
    return DESKEW ? t + ROWS + COLS - 1 : t + ROWS + c;
  endfunction

  task automatic clear_cap();
    for (int c = 0; c < COLS; c++) begin
      res_v[c].delete();
      res_t[c].delete();
    end
    done_n = 0;
    done_t = 0;
  endtask

  task automatic load_weights(input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3);
    logic [31:0] beats [4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    w_load_i = 1'b1;
    tick();
    w_load_i = 1'b0;
    check("load_w_ready", longint'(w_ready_o), 1);
    for (int k = 0; k < ROWS; k++) begin
      w_valid_i = 1'b1;
      w_data_i  = beats[k];
      tick();
    end
    w_valid_i = 1'b0;
    w_data_i  = '0;
    check("load_done_ready", longint'(ifmap_ready_o), 1);
  endtask

  task automatic send_vec(input logic [31:0] x, input logic last, output int t);
    ifmap_valid_i = 1'b1;
    ifmap_data_i  = x;
    ifmap_last_i  = last;
    t = cyc;
    check("vec_accept_ready", longint'(ifmap_ready_o), 1);
    tick();
    ifmap_valid_i = 1'b0;
    ifmap_data_i  = '0;
    ifmap_last_i  = 1'b0;
  endtask

  task automatic verify_col(input string tag, input int c, input int idx,
                            input int v, input int t);
    if (res_v[c].size() > idx) begin
      check($sformatf("%s_val_c%0d_%0d", tag, c, idx), res_v[c][idx], v);
      check($sformatf("%s_time_c%0d_%0d", tag, c, idx), res_t[c][idx], t);
    end else begin
      check($sformatf("%s_missing_c%0d_%0d", tag, c, idx), res_v[c].size(), idx + 1);
    end
  endtask

  task automatic run_single(input string tag, input logic [31:0] x, input int v);
    int t;
    clear_cap();
    send_vec(x, 1'b1, t);
    repeat (14) tick();
    for (int c = 0; c < COLS; c++) begin
      check($sformatf("%s_count_c%0d", tag, c), res_v[c].size(), 1);
      verify_col(tag, c, 0, v, exp_t(t, c));
    end
    check({tag, "_done_n"}, done_n, 1);
    check({tag, "_done_t"}, done_t, t + DONE_LAT);
  endtask

  initial begin
    int t, t0, t1, t2, tot;

    // Reset
    tick();
    tick();
    check("rst_w_ready", longint'(w_ready_o), 0);
    check("rst_ifmap_ready", longint'(ifmap_ready_o), 0);
    check("rst_psum_valid", longint'(psum_valid_o), 0);
    check("rst_psum_data", longint'(|psum_data_o), 0);
    check("rst_busy", longint'(busy_o), 0);
    check("rst_done", longint'(done_o), 0);
    rst = 1'b0;
    tick();
    check("idle_w_ready", longint'(w_ready_o), 0);

    // Identity weights, x = [1,2,3,4]
    load_weights(32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001);
    clear_cap();
    send_vec(32'h04030201, 1'b1, t);
    check("id_busy_drain", longint'(busy_o), 1);
    repeat (14) tick();
    for (int c = 0; c < COLS; c++) begin
      check($sformatf("id_count_c%0d", c), res_v[c].size(), 1);
      verify_col("id", c, 0, c + 1, exp_t(t, c));
    end
    check("id_done_n", done_n, 1);
    check("id_done_t", done_t, t + DONE_LAT);
    check("id_back_ready", longint'(ifmap_ready_o), 1);
    check("id_not_busy", longint'(busy_o), 0);

    // Extremes
    load_weights(32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080);
    run_single("neg_neg", 32'h80808080, 65536);
    load_weights(32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f, 32'h7f7f7f7f);
    run_single("pos_neg", 32'h80808080, -65024);

    // Weight-load ordering: rows end up 40,30,20,10
    load_weights(32'h0a0a0a0a, 32'h14141414, 32'h1e1e1e1e, 32'h28282828);
    run_single("order_x0", 32'h00000001, 40);
    run_single("order_x3", 32'h01000000, 10);

    // Back-to-back with a bubble
    clear_cap();
    send_vec(32'h01010101, 1'b0, t0);
    send_vec(32'h00000002, 1'b0, t1);
    tick();
    send_vec(32'h03000000, 1'b1, t2);
    repeat (16) tick();
    for (int c = 0; c < COLS; c++) begin
      check($sformatf("b2b_count_c%0d", c), res_v[c].size(), 3);
      verify_col("b2b", c, 0, 100, exp_t(t0, c));
      verify_col("b2b", c, 1, 80, exp_t(t1, c));
      verify_col("b2b", c, 2, 30, exp_t(t2, c));
    end
    check("b2b_done_n", done_n, 1);
    check("b2b_done_t", done_t, t2 + DONE_LAT);

    // Control corners
    clear_cap();
    ifmap_valid_i = 1'b1;
    ifmap_data_i  = 32'h00000001;
    ifmap_last_i  = 1'b0;
    w_load_i      = 1'b1;
    t0 = cyc;
    check("ctl_ready", longint'(ifmap_ready_o), 1);
    tick();
    ifmap_valid_i = 1'b0;
    ifmap_data_i  = '0;
    w_load_i      = 1'b0;
    check("ctl_no_reload", longint'(w_ready_o), 0);
    check("ctl_in_compute", longint'(ifmap_ready_o), 1);
    w_load_i = 1'b1;
    tick();
    w_load_i = 1'b0;
    check("ctl_load_ignored", longint'(w_ready_o), 0);
    check("ctl_busy", longint'(busy_o), 1);
    send_vec(32'h00000100, 1'b1, t1);
    repeat (14) tick();
    for (int c = 0; c < COLS; c++) begin
      verify_col("ctl", c, 0, 40, exp_t(t0, c));
      verify_col("ctl", c, 1, 30, exp_t(t1, c));
    end
    check("ctl_done_n", done_n, 1);

    // Reset mid-COMPUTE
    clear_cap();
    send_vec(32'h01010101, 1'b0, t0);
    send_vec(32'h01010101, 1'b0, t1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_cap();
    repeat (16) tick();
    tot = 0;
    for (int c = 0; c < COLS; c++) tot = tot + res_v[c].size();
    check("rstmid_no_valid", tot, 0);
    check("rstmid_no_done", done_n, 0);
    check("rstmid_w_ready", longint'(w_ready_o), 0);
    check("rstmid_ifmap_ready", longint'(ifmap_ready_o), 0);
    check("rstmid_busy", longint'(busy_o), 0);
    w_load_i = 1'b1;
    tick();
    w_load_i = 1'b0;
    check("rstmid_reload", longint'(w_ready_o), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
